// File: rtl/sprite_pixel_store.sv
// rtl/sprite_pixel_store.sv - indexed WIDTHxHEIGHT sprite store, stream-loaded, line scan-out with x/y mirroring
// Optional macro SPRITE_INIT_PATTERN_EN: reset fills the store with a checkerboard.
module sprite_pixel_store #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10,
    parameter int BPP    = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           load_start,
    input  logic           load_valid,
    input  logic [BPP-1:0] load_data,
    output logic           load_ready,
    output logic           load_done,
    input  logic           frame_start,
    input  logic           line_start,
    input  logic           pixel_en,
    input  logic           mirror_x,
    input  logic           mirror_y,
    output logic [BPP-1:0] pixel_out,
    output logic           line_active
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(N - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t         state;
    logic [AW-1:0]  wr_ptr;
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic           mx;
    logic           my;
    logic [BPP-1:0] mem [N];

    logic           mem_we;
    logic           at_last_col;
    logic [RW-1:0]  row_next;
    logic [CW-1:0]  col_next;
    logic [AW-1:0]  rd_idx;

    // A load_start in the same cycle as a valid beat restarts the load without writing.
    assign mem_we = (state == LOAD) && load_valid && !load_start;

    always_comb begin
        at_last_col = mx ? (col == '0) : (col == COL_LAST);
        col_next    = mx ? col - 1'b1 : col + 1'b1;
        if (my)
            row_next = (row == '0) ? ROW_LAST : row - 1'b1;
        else
            row_next = (row == ROW_LAST) ? '0 : row + 1'b1;
        rd_idx = AW'(row) * AW'(WIDTH) + AW'(col);
    end

    assign pixel_out = line_active ? mem[rd_idx] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            row         <= '0;
            col         <= '0;
            mx          <= 1'b0;
            my          <= 1'b0;
            line_active <= 1'b0;
            load_ready  <= 1'b0;
            load_done   <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (load_start) begin
                state       <= LOAD;
                load_ready  <= 1'b1;
                wr_ptr      <= '0;
                line_active <= 1'b0;
            end else if (state == LOAD) begin
                if (load_valid) begin
                    if (wr_ptr == PTR_LAST) begin
                        state      <= IDLE;
                        load_ready <= 1'b0;
                        load_done  <= 1'b1;
                        wr_ptr     <= '0;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                end
            end else begin
                if (frame_start) begin
                    my          <= mirror_y;
                    row         <= mirror_y ? ROW_LAST : '0;
                    line_active <= 1'b0;
                end
                // line_start outranks pixel advance, so a restart on the final pixel keeps the row.
                if (line_start) begin
                    mx          <= mirror_x;
                    col         <= mirror_x ? COL_LAST : '0;
                    line_active <= 1'b1;
                end else if (pixel_en && line_active && !frame_start) begin
                    if (at_last_col) begin
                        line_active <= 1'b0;
                        row         <= row_next;
                    end else begin
                        col <= col_next;
                    end
                end
            end
        end
    end

`ifdef SPRITE_INIT_PATTERN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < HEIGHT; r++)
                for (int c = 0; c < WIDTH; c++)
                    mem[r*WIDTH + c] <= (((r + c) % 2) == 1) ? {BPP{1'b1}} : '0;
        end else if (mem_we) begin
            mem[wr_ptr] <= load_data;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr] <= load_data;
    end
`endif

endmodule

// File: tb/tb_sprite_pixel_store.sv
// tb/tb_sprite_pixel_store.sv - randomized directed bench for sprite_pixel_store against a raster-array model
module tb_sprite_pixel_store;

    localparam int W   = 10;
    localparam int H   = 10;
    localparam int BPP = 2;
    localparam int N   = W * H;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           load_start = 1'b0;
    logic           load_valid = 1'b0;
    logic [BPP-1:0] load_data = '0;
    logic           load_ready;
    logic           load_done;
    logic           frame_start = 1'b0;
    logic           line_start = 1'b0;
    logic           pixel_en = 1'b0;
    logic           mirror_x = 1'b0;
    logic           mirror_y = 1'b0;
    logic [BPP-1:0] pixel_out;
    logic           line_active;

    int checks = 0;
    int errors = 0;
    int ref_mem [N];
    int exp_row = 0;
    bit exp_my = 1'b0;

    sprite_pixel_store #(.WIDTH(W), .HEIGHT(H), .BPP(BPP)) dut (
        .clk(clk), .reset_n(reset_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_done(load_done),
        .frame_start(frame_start), .line_start(line_start), .pixel_en(pixel_en),
        .mirror_x(mirror_x), .mirror_y(mirror_y),
        .pixel_out(pixel_out), .line_active(line_active)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_checkerboard;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                ref_mem[r*W + c] = ((r + c) % 2 == 1) ? (1 << BPP) - 1 : 0;
    endtask

    task automatic advance_model_row;
        exp_row = exp_my ? (exp_row + H - 1) % H : (exp_row + 1) % H;
    endtask

    task automatic frame(input bit myv);
        frame_start = 1'b1;
        mirror_y = myv;
        tick;
        frame_start = 1'b0;
        exp_my = myv;
        exp_row = myv ? H - 1 : 0;
        chk("frame_line_inactive", line_active, 0);
    endtask

    // Emits one full row; optionally starts a frame in the same cycle as line_start.
    task automatic scan_line(input bit mxv, input bit fs, input bit myv);
        int c;
        mirror_x = mxv;
        line_start = 1'b1;
        if (fs) begin
            frame_start = 1'b1;
            mirror_y = myv;
            exp_my = myv;
            exp_row = myv ? H - 1 : 0;
        end
        tick;
        line_start = 1'b0;
        frame_start = 1'b0;
        for (int k = 0; k < W; k++) begin
            c = mxv ? W - 1 - k : k;
            chk($sformatf("active r%0d k%0d", exp_row, k), line_active, 1);
            chk($sformatf("pixel r%0d c%0d", exp_row, c), pixel_out, ref_mem[exp_row*W + c]);
            pixel_en = 1'b1;
            tick;
            pixel_en = 1'b0;
        end
        chk("line_end_inactive", line_active, 0);
        chk("line_end_pixel0", pixel_out, 0);
        advance_model_row();
    endtask

    task automatic start_load;
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        chk("load_ready_on", load_ready, 1);
        chk("load_line_inactive", line_active, 0);
        chk("load_pixel0", pixel_out, 0);
    endtask

    // mode 0: random pixels, mode 1: index mod 4.  toggle inserts an idle beat after each write.
    task automatic write_px(input int n, input int mode, input bit toggle);
        int v;
        for (int i = 0; i < n; i++) begin
            v = (mode == 1) ? i % 4 : int'($urandom_range(0, (1 << BPP) - 1));
            ref_mem[i] = v;
            load_valid = 1'b1;
            load_data = BPP'(v);
            tick;
            load_valid = 1'b0;
            if (i < N - 1) begin
                chk($sformatf("no_early_done w%0d", i), load_done, 0);
                chk($sformatf("ready_mid w%0d", i), load_ready, 1);
                if (toggle) begin
                    load_data = BPP'($urandom);
                    tick;
                    chk("ready_idle_beat", load_ready, 1);
                    chk("done_idle_beat", load_done, 0);
                end
            end
        end
        if (n == N) begin
            chk("load_done_pulse", load_done, 1);
            chk("load_ready_off", load_ready, 0);
            tick;
            chk("load_done_single", load_done, 0);
        end
    endtask

    initial begin
        tick;
        tick;
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_line_active", line_active, 0);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_load_done", load_done, 0);
        reset_n = 1'b1;
        tick;

`ifdef SPRITE_INIT_PATTERN_EN
        model_checkerboard();
        scan_line(1'b0, 1'b1, 1'b0);
        scan_line(1'b0, 1'b0, 1'b0);
`endif

        // Full random load with valid toggling, then raster readback through row 3.
        start_load();
        write_px(N, 0, 1'b1);
        frame(1'b0);
        for (int r = 0; r < 4; r++)
            scan_line(1'($urandom_range(0, 1)), 1'b0, 1'b0);

        // Index-mod-4 pattern, mirrored row 0 started in the same cycle as the frame.
        start_load();
        write_px(N, 1, 1'b1);
        begin
            int expect_row0 [W] = '{1, 0, 3, 2, 1, 0, 3, 2, 1, 0};
            mirror_x = 1'b1;
            mirror_y = 1'b0;
            frame_start = 1'b1;
            line_start = 1'b1;
            tick;
            frame_start = 1'b0;
            line_start = 1'b0;
            for (int k = 0; k < W; k++) begin
                chk($sformatf("mirror_x_row0 k%0d", k), pixel_out, expect_row0[k]);
                pixel_en = 1'b1;
                tick;
                pixel_en = 1'b0;
            end
            chk("mirror_x_end", line_active, 0);
        end

        // Vertical mirror: 11 lines walk rows 9..0 then wrap to 9.
        start_load();
        write_px(N, 0, 1'b0);
        frame(1'b1);
        for (int l = 0; l < H + 1; l++)
            scan_line(1'($urandom_range(0, 1)), 1'b0, 1'b0);

        // pixel_en with no active line must not move the row.
        frame(1'b0);
        for (int i = 0; i < 3; i++) begin
            pixel_en = 1'b1;
            tick;
            pixel_en = 1'b0;
            chk("idle_pixel_en_inactive", line_active, 0);
        end
        scan_line(1'b0, 1'b0, 1'b0);

        // line_start on the final pixel_en restarts the same row.
        mirror_x = 1'b0;
        line_start = 1'b1;
        tick;
        line_start = 1'b0;
        for (int k = 0; k < W - 1; k++) begin
            pixel_en = 1'b1;
            tick;
            pixel_en = 1'b0;
        end
        pixel_en = 1'b1;
        line_start = 1'b1;
        tick;
        pixel_en = 1'b0;
        line_start = 1'b0;
        chk("restart_active", line_active, 1);
        chk("restart_pixel", pixel_out, ref_mem[exp_row*W]);
        for (int k = 0; k < W; k++) begin
            chk($sformatf("restart_row k%0d", k), pixel_out, ref_mem[exp_row*W + k]);
            pixel_en = 1'b1;
            tick;
            pixel_en = 1'b0;
        end
        chk("restart_end", line_active, 0);
        advance_model_row();
        scan_line(1'b1, 1'b0, 1'b0);

        // load_start kills an active line; aborted burst yields no load_done.
        mirror_x = 1'b0;
        line_start = 1'b1;
        tick;
        line_start = 1'b0;
        chk("pre_abort_active", line_active, 1);
        start_load();
        write_px(40, 0, 1'b0);
        chk("abort_no_done", load_done, 0);
        start_load();
        write_px(N, 0, 1'b0);
        frame(1'b0);
        for (int r = 0; r < H; r++)
            scan_line(1'($urandom_range(0, 1)), 1'b0, 1'b0);

        // Asynchronous reset in the middle of a line.
        frame(1'b1);
        mirror_x = 1'b0;
        line_start = 1'b1;
        tick;
        line_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pixel_en = 1'b1;
            tick;
            pixel_en = 1'b0;
        end
        chk("pre_reset_active", line_active, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_active", line_active, 0);
        chk("async_rst_pixel", pixel_out, 0);
        tick;
        reset_n = 1'b1;
        tick;
`ifdef SPRITE_INIT_PATTERN_EN
        model_checkerboard();
`endif
        exp_row = 0;
        exp_my = 1'b0;
        scan_line(1'b0, 1'b0, 1'b0);
        scan_line(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
